// File: rtl/mini_riscv_pkg.sv
// Shared definitions for the mini_riscv core: opcode/funct encodings, FSM states,
// ALU operations and the instruction decoder.
package mini_riscv_pkg;

  localparam logic [6:0] OPC_R = 7'h33;
  localparam logic [6:0] OPC_I = 7'h13;
  localparam logic [6:0] OPC_B = 7'h63;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {StFetch, StExec, StWb} state_e;

  typedef enum logic [1:0] {AluAdd, AluSub, AluAnd, AluOr} alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    use_imm;
    logic    we;
    logic    is_beq;
  } dec_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  // Anything not explicitly recognised decodes to a NOP (no write, no branch).
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.alu_op  = AluAdd;
    d.use_imm = 1'b0;
    d.we      = 1'b0;
    d.is_beq  = 1'b0;
    case (ir[6:0])
      OPC_R: begin
        if (ir[31:25] == F7_BASE) begin
          case (ir[14:12])
            F3_ADD_SUB: begin d.alu_op = AluAdd; d.we = 1'b1; end
            F3_OR:      begin d.alu_op = AluOr;  d.we = 1'b1; end
            F3_AND:     begin d.alu_op = AluAnd; d.we = 1'b1; end
            default: ;
          endcase
        end else if (ir[31:25] == F7_ALT && ir[14:12] == F3_ADD_SUB) begin
          d.alu_op = AluSub;
          d.we     = 1'b1;
        end
      end
      OPC_I: begin
        if (ir[14:12] == F3_ADD_SUB) begin
          d.use_imm = 1'b1;
          d.we      = 1'b1;
        end
      end
      OPC_B: begin
        if (ir[14:12] == F3_BEQ) d.is_beq = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mini_riscv_if.sv
// Operand/result bundle between the mini_riscv datapath (master) and its ALU (slave).
interface mini_riscv_if;
  import mini_riscv_pkg::*;

  logic [31:0] a;
  logic [31:0] b;
  alu_op_e     alu_op;
  logic [31:0] result;
  logic        eq;

  modport master (output a, b, alu_op, input result, eq);
  modport slave  (input a, b, alu_op, output result, eq);
endinterface

// File: rtl/mini_riscv_alu.sv
// Combinational 32-bit ALU for mini_riscv; eq compares the raw operands for BEQ.
module mini_riscv_alu
  import mini_riscv_pkg::*;
(
  mini_riscv_if.slave alu
);

  always_comb begin
    alu.result = '0;
    unique case (alu.alu_op)
      AluAdd: alu.result = alu.a + alu.b;
      AluSub: alu.result = alu.a - alu.b;
      AluAnd: alu.result = alu.a & alu.b;
      AluOr:  alu.result = alu.a | alu.b;
    endcase
    alu.eq = (alu.a == alu.b);
  end

endmodule

// File: rtl/mini_riscv.sv
// Multi-cycle RV32I-subset core (ADD/SUB/AND/OR/ADDI/BEQ), 3 cycles per instruction.
// Define MINI_RISCV_TRACE_EN to print a per-instruction trace at writeback.
module mini_riscv
  import mini_riscv_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  // Program storage is loaded externally and deliberately survives reset.
  logic [31:0] imem [0:IMEM_WORDS-1] = '{default: '0};
  logic [31:0] regs [0:31];
  logic [31:0] pc;
  logic [31:0] ir;

  state_e      state_q;
  logic [31:0] res_q;
  logic        taken_q;
  logic        we_q;

  dec_t        dec;
  logic [31:0] fetch_word;
  logic [31:0] rs2_val;

  mini_riscv_if alu_bus ();

  mini_riscv_alu u_alu (
    .alu (alu_bus)
  );

  assign dec        = decode(ir);
  assign rs2_val    = regs[ir[24:20]];
  assign fetch_word = (pc[31:2] < 30'(IMEM_WORDS)) ? imem[pc[AW+1:2]] : '0;

  assign alu_bus.a      = regs[ir[19:15]];
  assign alu_bus.b      = dec.use_imm ? imm_i(ir) : rs2_val;
  assign alu_bus.alu_op = dec.alu_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc      <= '0;
      ir      <= '0;
      res_q   <= '0;
      taken_q <= 1'b0;
      we_q    <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          ir      <= fetch_word;
          state_q <= StExec;
        end
        StExec: begin
          res_q   <= alu_bus.result;
          taken_q <= dec.is_beq && alu_bus.eq;
          // x0 is never written, so it reads back as zero without a read-side mux.
          we_q    <= dec.we && (ir[11:7] != 5'd0);
          state_q <= StWb;
        end
        StWb: begin
          if (we_q) regs[ir[11:7]] <= res_q;
          pc      <= taken_q ? pc + imm_b(ir) : pc + 32'd4;
          state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

`ifdef MINI_RISCV_TRACE_EN
  always @(posedge clk) begin
    if (reset && state_q == StWb) begin
      if (taken_q) begin
        $display("[trace] pc=%08h ir=%08h branch taken -> %08h", pc, ir, pc + imm_b(ir));
      end else if (we_q) begin
        $display("[trace] pc=%08h ir=%08h x%0d <= %08h", pc, ir, ir[11:7], res_q);
      end else begin
        $display("[trace] pc=%08h ir=%08h", pc, ir);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mini_riscv.sv
// Self-checking bench for mini_riscv: directed programs plus random programs run in
// lockstep against an instruction-level reference model; also exercises the ALU alone.
module tb_mini_riscv;
  import mini_riscv_pkg::*;

  localparam int unsigned IMEM_WORDS = 64;

  logic clk = 1'b0;
  logic reset;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_imem [IMEM_WORDS];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] prog [$];

  always #5 clk = ~clk;

  mini_riscv #(.IMEM_WORDS(IMEM_WORDS)) dut (
    .clk   (clk),
    .reset (reset)
  );

  mini_riscv_if alu_bus ();

  mini_riscv_alu u_alu (
    .alu (alu_bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'h63};
  endfunction

  // Reference model: one call executes one whole instruction.
  function automatic logic [31:0] m_fetch();
    if ((m_pc >> 2) < IMEM_WORDS) return m_imem[m_pc[7:2]];
    return 32'd0;
  endfunction

  task automatic m_step();
    logic [31:0] w, a, b, res, nxt;
    logic wr;
    w   = m_fetch();
    a   = m_regs[w[19:15]];
    b   = m_regs[w[24:20]];
    res = 32'd0;
    wr  = 1'b0;
    nxt = m_pc + 32'd4;
    if (w[6:0] == 7'h33) begin
      if (w[14:12] == 3'd0 && w[31:25] == 7'h00) begin res = a + b; wr = 1'b1; end
      if (w[14:12] == 3'd0 && w[31:25] == 7'h20) begin res = a - b; wr = 1'b1; end
      if (w[14:12] == 3'd6 && w[31:25] == 7'h00) begin res = a | b; wr = 1'b1; end
      if (w[14:12] == 3'd7 && w[31:25] == 7'h00) begin res = a & b; wr = 1'b1; end
    end else if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
      res = a + {{20{w[31]}}, w[31:20]};
      wr  = 1'b1;
    end else if (w[6:0] == 7'h63 && w[14:12] == 3'd0 && a == b) begin
      nxt = m_pc + {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    end
    if (wr && w[11:7] != 5'd0) m_regs[w[11:7]] = res;
    m_pc = nxt;
  endtask

  task automatic m_reset();
    m_pc = 32'd0;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < IMEM_WORDS; i++) begin
      m_imem[i]     = (i < prog.size()) ? prog[i] : 32'd0;
      dut.imem[i]   = m_imem[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_pc", dut.pc, 32'd0);
    check("rst_ir", dut.ir, 32'd0);
    for (int r = 0; r < 32; r++) check($sformatf("rst_x%0d", r), dut.regs[r], 32'd0);
    m_reset();
  endtask

  // Steps n instructions, checking fetch, the mid-instruction hold and the retire state.
  task automatic run_prog(input int n);
    logic [31:0] w, pc_before;
    for (int k = 0; k < n; k++) begin
      w         = m_fetch();
      pc_before = m_pc;
      @(posedge clk); @(negedge clk);
      check("ir_fetch", dut.ir, w);
      @(posedge clk); @(negedge clk);
      check("pc_hold", dut.pc, pc_before);
      @(posedge clk); @(negedge clk);
      m_step();
      check("pc_retire", dut.pc, m_pc);
      for (int r = 0; r < 32; r++) check($sformatf("x%0d", r), dut.regs[r], m_regs[r]);
    end
  endtask

  task automatic gen_random_prog(input int len);
    int o;
    logic [4:0] rd, rs1, rs2;
    prog.delete();
    for (int i = 0; i < len; i++) begin
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: prog.push_back(enc_r(7'h00, 3'b000, rd, rs1, rs2));
        1: prog.push_back(enc_r(7'h20, 3'b000, rd, rs1, rs2));
        2: prog.push_back(enc_r(7'h00, 3'b111, rd, rs1, rs2));
        3: prog.push_back(enc_r(7'h00, 3'b110, rd, rs1, rs2));
        4, 5: prog.push_back(enc_i(rd, rs1, 12'($urandom)));
        6: begin
          o = int'($urandom_range(0, 32)) * 2 - 32;
          prog.push_back(enc_b(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 13'(o)));
        end
        default: prog.push_back($urandom);
      endcase
    end
  endtask

  initial begin
    logic [31:0] ea, eb, er;
    reset = 1'b0;

    // ALU on its own.
    for (int j = 0; j < 24; j++) begin
      ea = $urandom;
      eb = (j % 3 == 0) ? ea : $urandom;
      alu_bus.a      = ea;
      alu_bus.b      = eb;
      alu_bus.alu_op = alu_op_e'(2'(j));
      #1;
      case (j % 4)
        0: er = ea + eb;
        1: er = ea - eb;
        2: er = ea & eb;
        default: er = ea | eb;
      endcase
      check("alu_result", alu_bus.result, er);
      check("alu_eq", 32'(alu_bus.eq), 32'(ea == eb));
    end

    // Directed program.
    prog.delete();
    prog.push_back(enc_i(5'd1, 5'd0, 12'd5));
    prog.push_back(enc_i(5'd2, 5'd0, 12'd7));
    prog.push_back(enc_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2));
    prog.push_back(enc_r(7'h20, 3'b000, 5'd4, 5'd2, 5'd1));
    prog.push_back(enc_r(7'h00, 3'b111, 5'd5, 5'd1, 5'd2));
    prog.push_back(enc_r(7'h00, 3'b110, 5'd6, 5'd1, 5'd2));
    prog.push_back(enc_b(5'd0, 5'd0, 13'd8));
    prog.push_back(enc_i(5'd7, 5'd0, 12'd99));
    prog.push_back(enc_i(5'd7, 5'd0, 12'd11));
    prog.push_back(enc_b(5'd1, 5'd2, 13'd8));
    prog.push_back(enc_i(5'd0, 5'd0, 12'd9));
    prog.push_back(enc_i(5'd8, 5'd0, 12'hFFF));
    do_reset();
    load_prog();
    @(negedge clk);
    reset = 1'b1;
    run_prog(6);
    check("add_x3", dut.regs[3], 32'd12);
    check("sub_x4", dut.regs[4], 32'd2);
    check("and_x5", dut.regs[5], 32'd5);
    check("or_x6", dut.regs[6], 32'd7);
    run_prog(1);
    check("beq_taken_pc", dut.pc, 32'h20);
    check("x7_skipped", dut.regs[7], 32'd0);
    run_prog(1);
    check("x7_final", dut.regs[7], 32'd11);
    run_prog(1);
    check("beq_nt_pc", dut.pc, 32'h28);
    run_prog(4);
    check("x0_zero", dut.regs[0], 32'd0);
    check("addi_neg", dut.regs[8], 32'hFFFF_FFFF);
    check("nop_pc", dut.pc, 32'h38);

    // Reset asserted while ADD x3 is in EXEC.
    do_reset();
    @(negedge clk);
    reset = 1'b1;
    run_prog(2);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_pc", dut.pc, 32'd0);
    check("midrst_ir", dut.ir, 32'd0);
    check("midrst_x1", dut.regs[1], 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_x3", dut.regs[3], 32'd0);
    m_reset();
    reset = 1'b1;
    run_prog(6);
    check("rerun_x3", dut.regs[3], 32'd12);

    // Random programs, leaving a zero tail so fetches slide past the end of imem.
    for (int p = 0; p < 3; p++) begin
      gen_random_prog(40);
      do_reset();
      load_prog();
      @(negedge clk);
      reset = 1'b1;
      run_prog(100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
